pokey_chan_pair_div: RTL and testbench
======================================

Name: pokey_chan_pair_div

Overview:
- Audio-frequency divider for one POKEY channel pair (ch1/ch2).
- Two 8-bit down-counters reload from the AUDF registers and emit one-cycle borrow pulses. These pulses feed the downstream poly-counter/distortion stage.
- Supports 1.79 MHz fast clocking on ch1 and a joined 16-bit mode (ch2:ch1).
- Replaces per-bit loadable register cells with a behavioural counter pair. It keeps the same falling-edge timing and the same clock-enable semantics.

Parameters:
- CNT_W, 8, width of each channel counter.
- FAST_DLY, 3, extra reload hold cycles for ch1 in fast, unjoined mode (period N+4).
- JOIN_FAST_DLY, 6, extra reload hold cycles in fast, joined mode (period N+7).

Ports:
- clk  in  1  system clock; all state updates on the falling edge.
- R  in  1  reset; synchronous, active-high, sampled on negedge clk.
- enn  in  1  global clock enable; state advances only when 1.
- base_tick  in  1  selected 64 kHz/15 kHz tick, one enn-cycle wide.
- audf1  in  CNT_W  ch1 reload value.
- audf2  in  CNT_W  ch2 reload value.
- fast1  in  1  ch1 clocked every enn cycle instead of base_tick.
- join12  in  1  ch2:ch1 form one 16-bit counter.
- stimer  in  1  one-cycle strobe; reload both counters.
- out1  out  1  ch1 borrow pulse.
- out2  out  1  ch2 borrow pulse.
- cnt1  out  CNT_W  ch1 counter value.
- cnt2  out  CNT_W  ch2 counter value.

Behaviour:
- **Reset.** R=1 at negedge clk forces cnt1=cnt2=0, out1=out2=0 and the hold counters to 0. R is applied regardless of enn and overrides all other inputs.
- **Clock enable.** When enn=0, all state holds and out1/out2 are held at their current value.
- **Tick sources.**
  - tick1 = fast1 ? 1 : base_tick.
  - tick2 = base_tick when unjoined; unused when joined.
- **Unjoined channel with tick, hold=0:**
  - cnt != 0: cnt decrements.
  - cnt == 0: out pulses for this cycle, and the channel reloads.
  - Reload, slow: cnt <= audf at this same edge, giving period audf+1 ticks.
  - Reload, fast (ch1 only): hold <= FAST_DLY and cnt stays 0.
- **Hold counter.** When hold != 0, hold decrements every enn cycle regardless of tick. On the cycle hold reaches 1, cnt <= audf, so the first count is visible the following cycle.
  - Fast-mode period = audf1 + 4 clk-enabled cycles.
  - No borrow is generated while hold != 0.
- **Joined mode:**
  - {cnt2,cnt1} decrements on tick1.
  - out1 pulses when cnt1 == 0 at a tick (low-byte wrap).
  - out2 pulses when the 16-bit value == 0 at a tick; the counter then reloads with {audf2,audf1}.
  - Slow period = N+1 ticks; fast period = N+JOIN_FAST_DLY+1 cycles via the hold counter.
- **stimer=1.** cnt1 <= audf1 and cnt2 <= audf2, holds cleared, no pulse this cycle. stimer has priority over ticks and borrows.
- **AUDF writes mid-count** take effect only at the next reload or stimer.
- **Mode changes mid-count:**
  - fast1/join12 take effect at the next tick.
  - A hold already in progress completes with the length latched at borrow time.
- **Reset during a hold** clears the hold; no pending reload survives.

Decomposition:
- Shared package pokey_div_pkg holds CNT_W, FAST_DLY and JOIN_FAST_DLY.
- Natural sub-module: pokey_div8 (one 8-bit channel with tick, reload, hold, borrow and a cascade-in/zero-out pair).
- Instantiate pokey_div8 twice; join logic lives in the top.

Test Plan:
1. enn=1, base_tick every cycle, fast1=0, join12=0, audf1=0x02, stimer pulse -> out1 pulses every 3 cycles; cnt1 sequence 2,1,0,2.
2. fast1=1, audf1=0x00 -> out1 period 4 cycles; cnt1 held at 0 for 3 cycles between pulses.
3. join12=1, fast1=1, audf2=0x00, audf1=0x01 -> out2 period 8 cycles.
4. join12=1, fast1=0, audf2=0x01, audf1=0x00, base_tick every 2nd cycle -> out2 period 514 cycles; out1 at each low-byte wrap.
5. Mid-hold with enn=0, assert R for one negedge -> next cycle cnt1=cnt2=0, outputs 0, no later pending reload.
6. Change audf1 0x05->0x02 mid-count; separately drive stimer and tick1 in the same cycle with cnt1=0:
   - New value is loaded only after the next borrow.
   - In the stimer cycle, cnt1=audf1 and no out1 pulse.

Source files
------------

// File: rtl/pokey_div_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pokey_div_pkg                                                            |
// | Shared sizing constants for the POKEY channel-pair audio divider.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package pokey_div_pkg;

  localparam int CNT_W         = 8;
  localparam int FAST_DLY      = 3;
  localparam int JOIN_FAST_DLY = 6;

  // Hold counter must be wide enough for the longer of the two reload delays.
  function automatic int holdWidth(input int fastDly, input int joinDly);
    int maxDly;
    maxDly = (fastDly > joinDly) ? fastDly : joinDly;
    return (maxDly < 1) ? 1 : $clog2(maxDly + 1);
  endfunction

endpackage : pokey_div_pkg
`default_nettype wire

// File: rtl/pokey_div8.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pokey_div8                                                               |
// | One channel down-counter: tick, reload, reload-hold, borrow, cascade.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pokey_div8 #(
  parameter int CNT_W  = 8,
  parameter int HOLD_W = 3
) (
  input  logic              clk,
  input  logic              R,
  input  logic              enn,
  input  logic              tick,
  input  logic              cascIn,
  input  logic              reloadOnZero,
  input  logic              fastReload,
  input  logic [HOLD_W-1:0] holdLen,
  input  logic              stimer,
  input  logic [CNT_W-1:0]  audf,
  output logic              borrow,
  output logic              zeroOut,
  output logic [CNT_W-1:0]  cnt
);

  logic [CNT_W-1:0]  r_cnt;
  logic [HOLD_W-1:0] r_hold;
  logic              r_borrow;

  logic w_holdIdle;
  logic w_step;
  logic w_cntZero;
  logic w_borrow;

  assign w_holdIdle = (r_hold == '0);
  assign w_cntZero  = (r_cnt == '0);
  // Channel is frozen while a reload hold is running.
  assign w_step     = tick & cascIn & w_holdIdle;
  assign w_borrow   = w_step & w_cntZero;

  always_ff @(negedge clk) begin
    if (R) begin
      r_cnt    <= '0;
      r_hold   <= '0;
      r_borrow <= 1'b0;
    end else if (enn) begin
      if (stimer) begin
        r_cnt    <= audf;
        r_hold   <= '0;
        r_borrow <= 1'b0;
      end else begin
        r_borrow <= w_borrow;
        if (!w_holdIdle) begin
          r_hold <= r_hold - 1'b1;
          if (r_hold == HOLD_W'(1)) begin
            r_cnt <= audf;
          end
        end else if (w_step) begin
          if (!w_cntZero || !reloadOnZero) begin
            // Non-zero count, or low byte of a joined pair wrapping through zero.
            r_cnt <= r_cnt - 1'b1;
          end else if (fastReload && (holdLen != '0)) begin
            r_hold <= holdLen;
          end else begin
            r_cnt <= audf;
          end
        end
      end
    end
  end

  assign cnt     = r_cnt;
  assign borrow  = r_borrow;
  assign zeroOut = w_cntZero & w_holdIdle;

endmodule : pokey_div8
`default_nettype wire

// File: rtl/pokey_chan_pair_div.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pokey_chan_pair_div                                                      |
// | POKEY ch1/ch2 audio divider pair with fast clocking and 16-bit join.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pokey_chan_pair_div #(
  parameter int CNT_W         = pokey_div_pkg::CNT_W,
  parameter int FAST_DLY      = pokey_div_pkg::FAST_DLY,
  parameter int JOIN_FAST_DLY = pokey_div_pkg::JOIN_FAST_DLY
) (
  input  logic             clk,
  input  logic             R,
  input  logic             enn,
  input  logic             base_tick,
  input  logic [CNT_W-1:0] audf1,
  input  logic [CNT_W-1:0] audf2,
  input  logic             fast1,
  input  logic             join12,
  input  logic             stimer,
  output logic             out1,
  output logic             out2,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2
);

  import pokey_div_pkg::holdWidth;

  localparam int HOLD_W = holdWidth(FAST_DLY, JOIN_FAST_DLY);

  localparam logic [HOLD_W-1:0] c_fastHold = HOLD_W'(FAST_DLY);
  localparam logic [HOLD_W-1:0] c_joinHold = HOLD_W'(JOIN_FAST_DLY);

  logic              w_tick1;
  logic              w_tick2;
  logic              w_zero1;
  logic              w_zero2;
  logic              w_casc2;
  logic              w_reload1;
  logic              w_fast2;
  logic [HOLD_W-1:0] w_hold1Len;

  assign w_tick1    = fast1 | base_tick;
  // Joined: ch2 is the high byte, stepping only when the low byte borrows.
  assign w_tick2    = join12 ? w_tick1 : base_tick;
  assign w_casc2    = join12 ? w_zero1 : 1'b1;
  // Joined: low byte reloads only when the whole 16-bit value is zero.
  assign w_reload1  = ~join12 | w_zero2;
  assign w_fast2    = join12 & fast1;
  assign w_hold1Len = join12 ? c_joinHold : c_fastHold;

  pokey_div8 #(
    .CNT_W  (CNT_W),
    .HOLD_W (HOLD_W)
  ) u_ch1 (
    .clk          (clk),
    .R            (R),
    .enn          (enn),
    .tick         (w_tick1),
    .cascIn       (1'b1),
    .reloadOnZero (w_reload1),
    .fastReload   (fast1),
    .holdLen      (w_hold1Len),
    .stimer       (stimer),
    .audf         (audf1),
    .borrow       (out1),
    .zeroOut      (w_zero1),
    .cnt          (cnt1)
  );

  pokey_div8 #(
    .CNT_W  (CNT_W),
    .HOLD_W (HOLD_W)
  ) u_ch2 (
    .clk          (clk),
    .R            (R),
    .enn          (enn),
    .tick         (w_tick2),
    .cascIn       (w_casc2),
    .reloadOnZero (1'b1),
    .fastReload   (w_fast2),
    .holdLen      (c_joinHold),
    .stimer       (stimer),
    .audf         (audf2),
    .borrow       (out2),
    .zeroOut      (w_zero2),
    .cnt          (cnt2)
  );

endmodule : pokey_chan_pair_div
`default_nettype wire

// File: tb/tb_pokey_chan_pair_div.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pokey_chan_pair_div                                                   |
// | Directed self-checking bench for the POKEY channel-pair divider.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pokey_chan_pair_div;

  logic       clk = 1'b0;
  logic       R, enn, base_tick, fast1, join12, stimer;
  logic [7:0] audf1, audf2;
  logic       out1, out2;
  logic [7:0] cnt1, cnt2;

  int total = 0;
  int bad   = 0;

  pokey_chan_pair_div dut (
    .clk       (clk),
    .R         (R),
    .enn       (enn),
    .base_tick (base_tick),
    .audf1     (audf1),
    .audf2     (audf2),
    .fast1     (fast1),
    .join12    (join12),
    .stimer    (stimer),
    .out1      (out1),
    .out2      (out2),
    .cnt1      (cnt1),
    .cnt2      (cnt2)
  );

  always #5 clk = ~clk;

  // Advance past one active (falling) edge and settle.
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [6:0] t1Cnt1 [7];
    logic [6:0] t1Cnt2 [7];
    logic [6:0] t1Out1;
    logic [6:0] t1Out2;
    logic [7:0] t2Out1;
    logic [9:0] t3Out2;
    logic [9:0] t3Cnt1;
    int         firstOut2;
    int         secondOut2;
    int         nOut1;
    int         nOut2;

    // Reset overrides a simultaneous stimer
    R = 1'b1; enn = 1'b1; base_tick = 1'b1; fast1 = 1'b0; join12 = 1'b0;
    stimer = 1'b1; audf1 = 8'h55; audf2 = 8'h66;
    cyc();
    chk("rst_cnt1", 32'(cnt1), 32'h0);
    chk("rst_cnt2", 32'(cnt2), 32'h0);
    chk("rst_out1", 32'(out1), 32'h0);
    chk("rst_out2", 32'(out2), 32'h0);

    // Slow unjoined, tick every cycle
    R = 1'b0; audf1 = 8'h02; audf2 = 8'h03; stimer = 1'b1;
    cyc();
    chk("t1_stim_cnt1", 32'(cnt1), 32'h2);
    chk("t1_stim_cnt2", 32'(cnt2), 32'h3);
    chk("t1_stim_out1", 32'(out1), 32'h0);
    stimer = 1'b0;
    t1Cnt1 = '{7'd1, 7'd0, 7'd2, 7'd1, 7'd0, 7'd2, 7'd1};
    t1Cnt2 = '{7'd2, 7'd1, 7'd0, 7'd3, 7'd2, 7'd1, 7'd0};
    t1Out1 = 7'b0100100;
    t1Out2 = 7'b0001000;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk($sformatf("t1_cnt1[%0d]", i), 32'(cnt1), 32'(t1Cnt1[i]));
      chk($sformatf("t1_cnt2[%0d]", i), 32'(cnt2), 32'(t1Cnt2[i]));
      chk($sformatf("t1_out1[%0d]", i), 32'(out1), 32'(t1Out1[i]));
      chk($sformatf("t1_out2[%0d]", i), 32'(out2), 32'(t1Out2[i]));
    end

    // enn=0 freezes state including a high pulse output
    enn = 1'b0;
    cyc(); cyc();
    chk("enn0_cnt1", 32'(cnt1), 32'h2);
    chk("enn0_out1", 32'(out1), 32'h1);
    chk("enn0_cnt2", 32'(cnt2), 32'h1);
    enn = 1'b1;

    // Fast ch1, audf1=0: period 4, base_tick idle
    fast1 = 1'b1; audf1 = 8'h00; base_tick = 1'b0; stimer = 1'b1;
    cyc();
    chk("t2_stim_cnt1", 32'(cnt1), 32'h0);
    chk("t2_stim_out1", 32'(out1), 32'h0);
    stimer = 1'b0;
    t2Out1 = 8'b00010001;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk($sformatf("t2_out1[%0d]", i), 32'(out1), 32'(t2Out1[i]));
      chk($sformatf("t2_cnt1[%0d]", i), 32'(cnt1), 32'h0);
    end

    // Joined fast, value 0x0001: out2 period 8
    join12 = 1'b1; fast1 = 1'b1; audf2 = 8'h00; audf1 = 8'h01; stimer = 1'b1;
    cyc();
    chk("t3_stim_cnt1", 32'(cnt1), 32'h1);
    chk("t3_stim_cnt2", 32'(cnt2), 32'h0);
    stimer = 1'b0;
    t3Out2 = 10'b10_0000_0010;
    t3Cnt1 = 10'b00_1000_0000;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk($sformatf("t3_out2[%0d]", i), 32'(out2), 32'(t3Out2[i]));
      chk($sformatf("t3_out1[%0d]", i), 32'(out1), 32'(t3Out2[i]));
      chk($sformatf("t3_cnt1[%0d]", i), 32'(cnt1), 32'(t3Cnt1[i]));
    end

    // Reset while a hold is in progress and enn=0
    enn = 1'b0;
    cyc();
    chk("t5_hold_out2", 32'(out2), 32'h1);
    R = 1'b1;
    cyc();
    chk("t5_rst_cnt1", 32'(cnt1), 32'h0);
    chk("t5_rst_cnt2", 32'(cnt2), 32'h0);
    chk("t5_rst_out1", 32'(out1), 32'h0);
    chk("t5_rst_out2", 32'(out2), 32'h0);
    R = 1'b0; enn = 1'b1; join12 = 1'b0; fast1 = 1'b0; base_tick = 1'b0;
    audf1 = 8'h01; audf2 = 8'h04;
    for (int i = 0; i < 8; i++) cyc();
    chk("t5_nopend_cnt1", 32'(cnt1), 32'h0);
    chk("t5_nopend_cnt2", 32'(cnt2), 32'h0);

    // Joined slow, value 0x0100, tick every 2nd cycle: out2 period 514
    join12 = 1'b1; audf2 = 8'h01; audf1 = 8'h00; stimer = 1'b1;
    cyc();
    chk("t4_stim_val", 32'({cnt2, cnt1}), 32'h100);
    stimer = 1'b0;
    firstOut2 = -1; secondOut2 = -1; nOut1 = 0; nOut2 = 0;
    for (int k = 1; k <= 1028; k++) begin
      base_tick = (k % 2) == 1;
      cyc();
      if (k == 1) chk("t4_k1_out1", 32'(out1), 32'h1);
      if (k == 2) chk("t4_k2_val", 32'({cnt2, cnt1}), 32'h0FF);
      if (out1) nOut1++;
      if (out2) begin
        nOut2++;
        if (firstOut2 < 0) firstOut2 = k;
        else if (secondOut2 < 0) secondOut2 = k;
      end
    end
    chk("t4_first_out2", 32'(firstOut2), 32'd513);
    chk("t4_second_out2", 32'(secondOut2), 32'd1027);
    chk("t4_n_out2", 32'(nOut2), 32'd2);
    chk("t4_n_out1", 32'(nOut1), 32'd4);

    // AUDF write mid-count applies at next reload; stimer beats a borrow
    join12 = 1'b0; fast1 = 1'b0; base_tick = 1'b1; audf1 = 8'h05; stimer = 1'b1;
    cyc();
    chk("t6_stim_cnt1", 32'(cnt1), 32'h5);
    stimer = 1'b0;
    cyc(); cyc();
    chk("t6_mid_cnt1", 32'(cnt1), 32'h3);
    audf1 = 8'h02;
    cyc(); cyc(); cyc();
    chk("t6_zero_cnt1", 32'(cnt1), 32'h0);
    chk("t6_zero_out1", 32'(out1), 32'h0);
    cyc();
    chk("t6_reload_out1", 32'(out1), 32'h1);
    chk("t6_reload_cnt1", 32'(cnt1), 32'h2);
    cyc(); cyc();
    chk("t6_pre_cnt1", 32'(cnt1), 32'h0);
    audf1 = 8'h07; stimer = 1'b1;
    cyc();
    chk("t6_stick_cnt1", 32'(cnt1), 32'h7);
    chk("t6_stick_out1", 32'(out1), 32'h0);
    stimer = 1'b0;
    cyc();
    chk("t6_after_cnt1", 32'(cnt1), 32'h6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pokey_chan_pair_div
`default_nettype wire
